// File: rtl/wash_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wash_pkg
// Purpose : State encodings, frequency codes and phase-limit helper shared by
//           the washing-machine sequencer and its phase timer.
// Rev     : 1.0  initial release
// ============================================================================
package wash_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FILL   = 3'd1;
  localparam logic [2:0] ST_WASH   = 3'd2;
  localparam logic [2:0] ST_RINSE  = 3'd3;
  localparam logic [2:0] ST_SPIN   = 3'd4;
  localparam logic [2:0] ST_WASH2  = 3'd5;
  localparam logic [2:0] ST_RINSE2 = 3'd6;
  localparam logic [2:0] ST_DONE   = 3'd7;

  localparam logic [1:0] FREQ_1X = 2'd0;
  localparam logic [1:0] FREQ_2X = 2'd1;
  localparam logic [1:0] FREQ_4X = 2'd2;
  localparam logic [1:0] FREQ_8X = 2'd3;

  // Phase length in cycles; a zero result would never expire, so it becomes 1.
  function automatic logic [31:0] phase_limit(input logic [31:0] dur_s,
                                              input logic [31:0] base_hz,
                                              input logic [1:0]  freq_code);
    logic [63:0] base_cycles;
    logic [63:0] cycles;
    base_cycles = {32'd0, dur_s} * {32'd0, base_hz};
    case (freq_code)
      FREQ_1X: cycles = base_cycles;
      FREQ_2X: cycles = base_cycles << 1;
      FREQ_4X: cycles = base_cycles << 2;
      FREQ_8X: cycles = base_cycles << 3;
      default: cycles = base_cycles;
    endcase
    if (cycles[31:0] == 32'd0) begin
      phase_limit = 32'd1;
    end else begin
      phase_limit = cycles[31:0];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/wash_phase_timer.sv
`default_nettype none
// ============================================================================
// Module  : wash_phase_timer
// Purpose : 32-bit phase counter; pulses expire on the last cycle of a phase.
// Rev     : 1.0  initial release
// ============================================================================
module wash_phase_timer (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [31:0] limit,
  output logic        expire
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  assign expire = enable && !clear && (count_q == (limit - 32'd1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 32'd0;
    end else if (enable) begin
      count_d = expire ? 32'd0 : (count_q + 32'd1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wash_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module  : wash_cycle_controller
// Purpose : Coin-started wash sequencer with lid pause, cancel and per-run
//           latching of programme and clock frequency.
// Rev     : 1.0  initial release
// ============================================================================
module wash_cycle_controller
  import wash_pkg::*;
#(
  parameter int unsigned BASE_HZ = 1_000_000,
  parameter int unsigned FILL_S  = 120,
  parameter int unsigned WASH_S  = 300,
  parameter int unsigned RINSE_S = 120,
  parameter int unsigned SPIN_S  = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       coin_in,
  input  logic       double_wash,
  input  logic [1:0] clk_freq,
  input  logic       lid_open,
  input  logic       cancel,
  output logic [2:0] state,
  output logic       busy,
  output logic       water_valve,
  output logic       drum_motor,
  output logic       spin_motor,
  output logic       wash_done
);

  logic [2:0]  state_q, state_d;
  logic        dw_q, dw_d;
  logic [1:0]  freq_q, freq_d;
  logic [31:0] limit_q, limit_d;
  logic [31:0] dur_next;
  logic        run_active;
  logic        paused;
  logic        expire;

  assign run_active = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign paused     = (state_q == ST_SPIN) && lid_open;

  wash_phase_timer u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (!run_active || cancel),
    .enable (run_active && !paused),
    .limit  (limit_q),
    .expire (expire)
  );

  always_comb begin
    state_d = state_q;
    dw_d    = dw_q;
    freq_d  = freq_q;
    case (state_q)
      ST_IDLE: begin
        if (coin_in) begin
          state_d = ST_FILL;
          dw_d    = double_wash;
          freq_d  = clk_freq;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        // cancel outranks a same-cycle expiry
        if (cancel) begin
          state_d = ST_IDLE;
        end else if (expire) begin
          case (state_q)
            ST_FILL:   state_d = ST_WASH;
            ST_WASH:   state_d = ST_RINSE;
            ST_RINSE:  state_d = dw_q ? ST_WASH2 : ST_SPIN;
            ST_WASH2:  state_d = ST_RINSE2;
            ST_RINSE2: state_d = ST_SPIN;
            ST_SPIN:   state_d = ST_DONE;
            default:   state_d = ST_IDLE;
          endcase
        end
      end
    endcase
  end

  // Limit is registered alongside the state it belongs to.
  always_comb begin
    dur_next = 32'd0;
    case (state_d)
      ST_FILL:             dur_next = FILL_S;
      ST_WASH,  ST_WASH2:  dur_next = WASH_S;
      ST_RINSE, ST_RINSE2: dur_next = RINSE_S;
      ST_SPIN:             dur_next = SPIN_S;
      default:             dur_next = 32'd0;
    endcase
    limit_d = phase_limit(dur_next, BASE_HZ, freq_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dw_q    <= 1'b0;
      freq_q  <= FREQ_1X;
      limit_q <= 32'd1;
    end else begin
      state_q <= state_d;
      dw_q    <= dw_d;
      freq_q  <= freq_d;
      limit_q <= limit_d;
    end
  end

  assign state       = state_q;
  assign busy        = run_active;
  assign water_valve = (state_q == ST_FILL);
  assign drum_motor  = (state_q == ST_WASH)  || (state_q == ST_RINSE) ||
                       (state_q == ST_WASH2) || (state_q == ST_RINSE2);
  assign spin_motor  = (state_q == ST_SPIN) && !lid_open;
  assign wash_done   = (state_q == ST_DONE);

endmodule
`default_nettype wire
